// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback,
// bounds memory waits, counts retired instructions and traps on illegal input.
module multicycle_control_unit #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int WAIT_W       = 4,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr,
  input  logic             zero,
  input  logic             neg,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       imm_src,
  output logic [3:0]       alu_ctrl,
  output logic [3:0]       state_o,
  output logic             instr_done,
  output logic [CNT_W-1:0] instret,
  output logic             illegal,
  output logic             timeout
);

  // state    | meaning
  // FETCH    | read instruction at PC, PC <= PC+4
  // DECODE   | branch/jump target into ALUOut, dispatch on opcode
  // MEMADR   | rs1 + imm address for load/store
  // MEMREAD  | load data request
  // MEMWB    | load data into register file
  // MEMWRITE | store data request
  // EXEC_R   | register-register ALU op
  // EXEC_I   | register-immediate ALU op
  // ALUWB    | ALUOut into register file
  // BRANCH   | compare rs1/rs2, conditional PC update
  // JAL      | PC <= target, ALUOut <= oldPC+4
  // TRAP     | halted until reset
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3,
    MEMWB = 4'd4, MEMWRITE = 4'd5, EXEC_R = 4'd6, EXEC_I = 4'd7,
    ALUWB = 4'd8, BRANCH = 4'd9, JAL = 4'd10, TRAP = 4'd11
  } state_e;

  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111;

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   instret_q, instret_d;
  logic               illegal_q, illegal_d, timeout_q, timeout_d;
  logic               mem_wait;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       unused_instr;
  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign funct7_5     = instr[30];
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

  // Legal branches are beq/bne/blt/bge: funct3[1] clear; funct3[0] inverts the test.
  logic br_ok, br_taken;
  assign br_ok    = ~funct3[1];
  assign br_taken = (funct3[2] ? neg : zero) ^ funct3[0];

  function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic f7, input logic sub_ok);
    case (f3)
      3'b000:  alu_dec = (sub_ok && f7) ? 4'b0001 : 4'b0000;
      3'b001:  alu_dec = 4'b0110;
      3'b010:  alu_dec = 4'b0101;
      3'b100:  alu_dec = 4'b0100;
      3'b101:  alu_dec = f7 ? 4'b1000 : 4'b0111;
      3'b110:  alu_dec = 4'b0011;
      3'b111:  alu_dec = 4'b0010;
      default: alu_dec = 4'b0000;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      wait_q    <= '0;
      instret_q <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    wait_d    = '0;
    mem_wait  = 1'b0;
    instret_d = instret_q + CNT_W'(instr_done);
    case (state_q)
      FETCH:    if (mem_ready) state_d = DECODE; else mem_wait = 1'b1;
      DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_R:              state_d = EXEC_R;
          OP_I:              state_d = EXEC_I;
          OP_BR:             state_d = BRANCH;
          OP_JAL:            state_d = JAL;
          default: begin
            state_d   = TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      MEMADR:   state_d = (opcode == OP_STORE) ? MEMWRITE : MEMREAD;
      MEMREAD:  if (mem_ready) state_d = MEMWB; else mem_wait = 1'b1;
      MEMWRITE: if (mem_ready) state_d = FETCH; else mem_wait = 1'b1;
      MEMWB, ALUWB:   state_d = FETCH;
      EXEC_R, EXEC_I: state_d = ALUWB;
      JAL:            state_d = ALUWB;
      BRANCH: begin
        if (br_ok) state_d = FETCH;
        else begin
          state_d   = TRAP;
          illegal_d = 1'b1;
        end
      end
      TRAP:     state_d = TRAP;
      default:  state_d = FETCH;
    endcase
    // A ready in the last allowed cycle completes normally; only a miss there traps.
    if (mem_wait) begin
      if (wait_q == WAIT_W'(MEM_WAIT_MAX - 1)) begin
        state_d   = TRAP;
        timeout_d = 1'b1;
      end else begin
        wait_d = wait_q + 1'b1;
      end
    end
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    instr_done = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    imm_src    = 3'b000;
    alu_ctrl   = 4'b0000;
    case (state_q)
      FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = (opcode == OP_JAL) ? 3'b011 : 3'b010;
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = (opcode == OP_STORE) ? 3'b001 : 3'b000;
      end
      MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      MEMWRITE: begin
        mem_req    = 1'b1;
        mem_we     = 1'b1;
        adr_src    = 1'b1;
        instr_done = mem_ready;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      EXEC_R: begin
        alu_src_a = 2'b10;
        alu_ctrl  = alu_dec(funct3, funct7_5, 1'b1);
      end
      EXEC_I: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_ctrl  = alu_dec(funct3, funct7_5, 1'b0);
      end
      ALUWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      BRANCH: begin
        alu_src_a  = 2'b10;
        alu_ctrl   = 4'b0001;
        pc_write   = br_ok & br_taken;
        instr_done = br_ok;
      end
      JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
      end
      default: ;
    endcase
  end

  assign state_o = state_q;
  assign instret = instret_q;
  assign illegal = illegal_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench for multicycle_control_unit: per-instruction expected cycle traces
// built from the instruction class, compared every cycle against the DUT.
module tb_multicycle_control_unit;
  localparam int MWM = 15;

  logic        clk = 1'b0;
  logic        rst_n, zero, neg, mem_ready;
  logic [31:0] instr;
  logic        mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, instr_done;
  logic [1:0]  result_src, alu_src_a, alu_src_b;
  logic [2:0]  imm_src;
  logic [3:0]  alu_ctrl, state_o;
  logic [31:0] instret;
  logic        illegal, timeout;

  multicycle_control_unit #(.MEM_WAIT_MAX(MWM), .WAIT_W(4), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .neg(neg),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_src(imm_src), .alu_ctrl(alu_ctrl), .state_o(state_o),
    .instr_done(instr_done), .instret(instret), .illegal(illegal), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Expected control bits: {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, instr_done}
  localparam logic [6:0] C_REQ = 7'h40, C_WE = 7'h20, C_ADR = 7'h10, C_IR = 7'h08;
  localparam logic [6:0] C_PC = 7'h04, C_RW = 7'h02, C_DONE = 7'h01;
  localparam logic [3:0] S_FE = 0, S_DE = 1, S_MA = 2, S_MR = 3, S_MWB = 4, S_MW = 5;
  localparam logic [3:0] S_ER = 6, S_EI = 7, S_WB = 8, S_BR = 9, S_JAL = 10, S_TR = 11;

  typedef struct {
    logic [3:0] st;
    logic       rdy;
    logic [6:0] ctl;
    logic [3:0] alu;
    logic [1:0] rs;
    logic [2:0] imm;
    logic [1:0] as_;
    logic [1:0] bs;
  } rec_t;

  rec_t        exp_q[$];
  int          n_cmp = 0, n_err = 0;
  logic [31:0] instret_m = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic void push(input logic [3:0] st, input logic rdy, input logic [6:0] ctl,
                               input logic [3:0] alu, input logic [1:0] rs, input logic [2:0] imm,
                               input logic [1:0] as_, input logic [1:0] bs);
    rec_t r;
    r.st = st; r.rdy = rdy; r.ctl = ctl; r.alu = alu;
    r.rs = rs; r.imm = imm; r.as_ = as_; r.bs = bs;
    exp_q.push_back(r);
  endfunction

  function automatic logic rnd_bit();
    return logic'($urandom_range(0, 1));
  endfunction

  // A memory phase: 'waits' cycles without ready, then one ready cycle, unless the bound is hit.
  function automatic bit mem_phase(input logic [3:0] st, input int waits, input logic [6:0] cw,
                                   input logic [6:0] cr, input logic [1:0] rs,
                                   input logic [1:0] as_, input logic [1:0] bs);
    int lows = (waits >= MWM) ? MWM : waits;
    for (int k = 0; k < lows; k++) push(st, 1'b0, cw, 4'd0, rs, 3'd0, as_, bs);
    if (waits >= MWM) return 1'b1;
    push(st, 1'b1, cr, 4'd0, rs, 3'd0, as_, bs);
    return 1'b0;
  endfunction

  // ALU op the ISA assigns to funct3 (ADD, SLL, SLT, -, XOR, SRL, OR, AND), with SUB/SRA variants.
  function automatic logic [3:0] alu_exp(input logic [2:0] f3, input logic f7, input logic is_r);
    logic [3:0] t[8];
    logic [3:0] r;
    t = '{4'd0, 4'd6, 4'd5, 4'd0, 4'd4, 4'd7, 4'd3, 4'd2};
    r = t[f3];
    if (f3 == 3'd0 && is_r && f7) r = 4'd1;
    if (f3 == 3'd5 && f7) r = 4'd8;
    return r;
  endfunction

  function automatic void build(input logic [31:0] ins, input logic z, input logic n,
                                input int wf, input int wm,
                                output bit trapped, output bit ill, output bit tmo, output bit done);
    logic [6:0] op = ins[6:0];
    logic [2:0] f3 = ins[14:12];
    logic       f7 = ins[30];
    logic       taken;
    exp_q.delete();
    trapped = 0; ill = 0; tmo = 0; done = 0;
    if (mem_phase(S_FE, wf, C_REQ, C_REQ | C_IR | C_PC, 2'd2, 2'd0, 2'd2)) tmo = 1;
    else begin
      push(S_DE, rnd_bit(), 7'd0, 4'd0, 2'd0, (op == 7'b1101111) ? 3'd3 : 3'd2, 2'd1, 2'd1);
      case (op)
        7'b0000011: begin
          push(S_MA, rnd_bit(), 7'd0, 4'd0, 2'd0, 3'd0, 2'd2, 2'd1);
          if (mem_phase(S_MR, wm, C_REQ | C_ADR, C_REQ | C_ADR, 2'd0, 2'd0, 2'd0)) tmo = 1;
          else begin
            push(S_MWB, rnd_bit(), C_RW | C_DONE, 4'd0, 2'd1, 3'd0, 2'd0, 2'd0);
            done = 1;
          end
        end
        7'b0100011: begin
          push(S_MA, rnd_bit(), 7'd0, 4'd0, 2'd0, 3'd1, 2'd2, 2'd1);
          if (mem_phase(S_MW, wm, C_REQ | C_WE | C_ADR, C_REQ | C_WE | C_ADR | C_DONE,
                        2'd0, 2'd0, 2'd0)) tmo = 1;
          else done = 1;
        end
        7'b0110011: begin
          push(S_ER, rnd_bit(), 7'd0, alu_exp(f3, f7, 1'b1), 2'd0, 3'd0, 2'd2, 2'd0);
          push(S_WB, rnd_bit(), C_RW | C_DONE, 4'd0, 2'd0, 3'd0, 2'd0, 2'd0);
          done = 1;
        end
        7'b0010011: begin
          push(S_EI, rnd_bit(), 7'd0, alu_exp(f3, f7, 1'b0), 2'd0, 3'd0, 2'd2, 2'd1);
          push(S_WB, rnd_bit(), C_RW | C_DONE, 4'd0, 2'd0, 3'd0, 2'd0, 2'd0);
          done = 1;
        end
        7'b1100011: begin
          case (f3)
            3'd0: taken = z;
            3'd1: taken = !z;
            3'd4: taken = n;
            3'd5: taken = !n;
            default: ill = 1;
          endcase
          if (ill) push(S_BR, rnd_bit(), 7'd0, 4'd1, 2'd0, 3'd0, 2'd2, 2'd0);
          else begin
            push(S_BR, rnd_bit(), (taken ? C_PC : 7'd0) | C_DONE, 4'd1, 2'd0, 3'd0, 2'd2, 2'd0);
            done = 1;
          end
        end
        7'b1101111: begin
          push(S_JAL, rnd_bit(), C_PC, 4'd0, 2'd0, 3'd0, 2'd1, 2'd2);
          push(S_WB, rnd_bit(), C_RW | C_DONE, 4'd0, 2'd0, 3'd0, 2'd0, 2'd0);
          done = 1;
        end
        default: ill = 1;
      endcase
    end
    trapped = ill | tmo;
    if (trapped) for (int k = 0; k < 3; k++) push(S_TR, rnd_bit(), 7'd0, 4'd0, 2'd0, 3'd0, 2'd0, 2'd0);
  endfunction

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    instret_m = 0;
    check({tag, "_state"}, 32'(state_o), 32'd0);
    check({tag, "_instret"}, instret, 32'd0);
    check({tag, "_flags"}, {30'd0, illegal, timeout}, 32'd0);
  endtask

  // abort_at: -1 none, -2 random cycle, otherwise reset after that trace index
  task automatic run_instr(input logic [31:0] ins, input logic z, input logic n,
                           input int wf, input int wm, input int abort_at);
    bit trapped, ill, tmo, done;
    int ab = abort_at;
    build(ins, z, n, wf, wm, trapped, ill, tmo, done);
    if (ab == -2) ab = $urandom_range(0, exp_q.size() - 1);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      if (i == 0) begin
        instr = ins; zero = z; neg = n;
      end
      mem_ready = exp_q[i].rdy;
      #1;
      check("cyc",
            {8'd0, state_o, mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, instr_done,
             alu_ctrl, result_src, imm_src, alu_src_a, alu_src_b},
            {8'd0, exp_q[i].st, exp_q[i].ctl, exp_q[i].alu, exp_q[i].rs, exp_q[i].imm,
             exp_q[i].as_, exp_q[i].bs});
      if (i == ab) begin
        do_reset("abort");
        return;
      end
    end
    @(posedge clk);
    #1;
    if (done) instret_m = instret_m + 1;
    check("instret", instret, instret_m);
    check("illegal", 32'(illegal), 32'(ill));
    check("timeout", 32'(timeout), 32'(tmo));
    if (trapped) do_reset("trap_rst");
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w = $urandom;
    int          c = $urandom_range(0, 99);
    logic [6:0]  op;
    if (c < 20) w[6:0] = 7'b0110011;
    else if (c < 40) w[6:0] = 7'b0010011;
    else if (c < 52) w[6:0] = 7'b0000011;
    else if (c < 64) w[6:0] = 7'b0100011;
    else if (c < 84) w[6:0] = 7'b1100011;
    else if (c < 94) w[6:0] = 7'b1101111;
    else begin
      do op = 7'($urandom);
      while (op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111});
      w[6:0] = op;
    end
    // funct3=011 has no defined ALU op for R/I here
    if ((w[6:0] == 7'b0110011 || w[6:0] == 7'b0010011) && w[14:12] == 3'd3) w[14:12] = 3'd2;
    return w;
  endfunction

  function automatic int rand_wait();
    int c = $urandom_range(0, 39);
    if (c == 0) return MWM;
    if (c == 1) return MWM - 1;
    return $urandom_range(0, 3);
  endfunction

  initial begin
    rst_n = 1'b0; mem_ready = 1'b0; instr = 32'd0; zero = 1'b0; neg = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("reset_state", 32'(state_o), 32'd0);
    check("reset_instret", instret, 32'd0);
    check("reset_flags", {30'd0, illegal, timeout}, 32'd0);

    run_instr(32'h015A04B3, 1'b0, 1'b0, 0, 0, -1);       // add
    run_instr(32'h00812703, 1'b0, 1'b0, 0, 3, -1);       // lw, 3 wait cycles
    run_instr(32'h00E12423, 1'b0, 1'b0, 0, 0, -1);       // sw
    run_instr(32'h00A5C663, 1'b0, 1'b1, 0, 0, -1);       // blt taken
    run_instr(32'h00A5C663, 1'b0, 1'b0, 0, 0, -1);       // blt not taken
    run_instr(32'h015A04B3, 1'b0, 1'b0, MWM - 1, 0, -1); // ready on last allowed cycle
    run_instr(32'h00812703, 1'b0, 1'b0, 0, MWM - 1, -1);
    run_instr(32'h015A04B3, 1'b0, 1'b0, MWM, 0, -1);     // fetch timeout
    run_instr(32'h0000007F, 1'b0, 1'b0, 0, 0, -1);       // illegal opcode
    run_instr(32'h00812703, 1'b0, 1'b0, 0, 3, 4);        // reset mid-MEMREAD
    run_instr(32'h00A5E663, 1'b1, 1'b0, 0, 0, -1);       // illegal branch funct3

    for (int t = 0; t < 400; t++)
      run_instr(rand_instr(), rnd_bit(), rnd_bit(), rand_wait(), rand_wait(),
                ($urandom_range(0, 19) == 0) ? -2 : -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
